// File: rtl/latency_pipe_sched.sv
// rtl/latency_pipe_sched.sv - credit-guarded arbiter sharing one fixed-latency pipe, show-ahead output FIFO
// Build option: define LATPIPE_SCHED_FIXED_PRIO_EN for fixed-priority (lowest index wins) arbitration.
module latency_pipe_sched #(
  parameter int NUM_REQ      = 2,
  parameter int DATA_WIDTH   = 64,
  parameter int NUM_DELAY    = 5,
  parameter int MAX_INFLIGHT = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_data,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic                              rsp_valid,
  output logic [DATA_WIDTH-1:0]             rsp_data,
  output logic [$clog2(NUM_REQ)-1:0]        rsp_src,
  input  logic                              rsp_ready,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight_cnt
);

  localparam int SRC_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
  localparam int PTR_W = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;

  logic                  can_issue;
  logic                  grant_any;
  logic [SRC_W-1:0]      grant_idx;
  logic [DATA_WIDTH-1:0] grant_data;
  logic                  pop;
  logic                  wr;
  logic                  head_load;
  logic                  mem_pop;
  logic                  wr_to_mem;
  logic                  fifo_full;

  logic                  stage_valid [NUM_DELAY];
  logic [SRC_W-1:0]      stage_src   [NUM_DELAY];
  logic [DATA_WIDTH-1:0] stage_data  [NUM_DELAY];

  logic [DATA_WIDTH-1:0] mem_data [MAX_INFLIGHT];
  logic [SRC_W-1:0]      mem_src  [MAX_INFLIGHT];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      mem_cnt;

`ifndef LATPIPE_SCHED_FIXED_PRIO_EN
  logic [SRC_W-1:0]      rr_ptr;
`endif

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_INFLIGHT - 1)) ? '0 : p + 1'b1;
  endfunction

  // Credits cover pipe + FIFO; a pop frees its credit only from the next cycle on.
  assign can_issue = (inflight_cnt < CNT_W'(MAX_INFLIGHT));
  assign pop       = rsp_valid & rsp_ready;
  assign wr        = stage_valid[NUM_DELAY-1];

  // Pick at most one requester per cycle and expose the grant as req_ready.
  always_comb begin
    grant_any  = 1'b0;
    grant_idx  = '0;
    grant_data = '0;
    req_ready  = '0;
    if (!rst && can_issue) begin
`ifdef LATPIPE_SCHED_FIXED_PRIO_EN
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        if (req_valid[i]) begin
          grant_any  = 1'b1;
          grant_idx  = SRC_W'(i);
          grant_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
`else
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!grant_any && req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
          grant_any  = 1'b1;
          grant_idx  = SRC_W'((int'(rr_ptr) + k) % NUM_REQ);
          grant_data = req_data[((int'(rr_ptr) + k) % NUM_REQ)*DATA_WIDTH +: DATA_WIDTH];
        end
      end
`endif
      if (grant_any) req_ready[grant_idx] = 1'b1;
    end
  end

`ifndef LATPIPE_SCHED_FIXED_PRIO_EN
  // Round-robin pointer moves just past the last granted requester.
  always_ff @(posedge clk) begin
    if (rst) rr_ptr <= '0;
    else if (grant_any)
      rr_ptr <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
  end
`endif

  // Non-stallable delay line: every stage advances every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_DELAY; i++) begin
        stage_valid[i] <= 1'b0;
        stage_src[i]   <= '0;
        stage_data[i]  <= '0;
      end
    end else begin
      stage_valid[0] <= grant_any;
      stage_src[0]   <= grant_idx;
      stage_data[0]  <= grant_data;
      for (int i = 1; i < NUM_DELAY; i++) begin
        stage_valid[i] <= stage_valid[i-1];
        stage_src[i]   <= stage_src[i-1];
        stage_data[i]  <= stage_data[i-1];
      end
    end
  end

  // The head lives in the rsp_* registers; the array holds entries queued behind it.
  assign head_load = !rsp_valid || pop;
  assign mem_pop   = head_load && (mem_cnt != '0);
  assign wr_to_mem = wr && !(head_load && (mem_cnt == '0));
  assign fifo_full = (mem_cnt + CNT_W'(rsp_valid)) == CNT_W'(MAX_INFLIGHT);

  // Head register refill and storage pointers; data/src hold when the FIFO drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_src   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_cnt   <= '0;
    end else begin
      if (head_load) begin
        if (mem_cnt != '0) begin
          rsp_valid <= 1'b1;
          rsp_data  <= mem_data[rd_ptr];
          rsp_src   <= mem_src[rd_ptr];
          rd_ptr    <= ptr_inc(rd_ptr);
        end else if (wr) begin
          rsp_valid <= 1'b1;
          rsp_data  <= stage_data[NUM_DELAY-1];
          rsp_src   <= stage_src[NUM_DELAY-1];
        end else begin
          rsp_valid <= 1'b0;
        end
      end
      if (wr_to_mem) wr_ptr <= ptr_inc(wr_ptr);
      mem_cnt <= mem_cnt + CNT_W'(wr_to_mem) - CNT_W'(mem_pop);
    end
  end

  // FIFO storage array write port.
  always_ff @(posedge clk) begin
    if (wr_to_mem) begin
      mem_data[wr_ptr] <= stage_data[NUM_DELAY-1];
      mem_src[wr_ptr]  <= stage_src[NUM_DELAY-1];
    end
  end

  // Entries in pipe + FIFO: +1 per accept, -1 per pop.
  always_ff @(posedge clk) begin
    if (rst) inflight_cnt <= '0;
    else if (grant_any && !pop) inflight_cnt <= inflight_cnt + 1'b1;
    else if (!grant_any && pop) inflight_cnt <= inflight_cnt - 1'b1;
  end

`ifndef SYNTHESIS
  // Credits make this unreachable; a write into a full FIFO means the credit logic broke.
  always_ff @(posedge clk) begin
    if (!rst && wr && fifo_full) $error("latency_pipe_sched: write to full output FIFO");
  end
`endif

endmodule

// File: tb/tb_latency_pipe_sched.sv
// tb/tb_latency_pipe_sched.sv - scoreboard bench for latency_pipe_sched with randomized requesters
module tb_latency_pipe_sched;

  localparam int NR = 2;
  localparam int DW = 64;
  localparam int ND = 5;
  localparam int MI = 8;
  localparam int SW = $clog2(NR);
  localparam int CW = $clog2(MI + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_ready;
  logic              rsp_valid;
  logic [DW-1:0]     rsp_data;
  logic [SW-1:0]     rsp_src;
  logic              rsp_ready;
  logic [CW-1:0]     inflight_cnt;

  latency_pipe_sched #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .NUM_DELAY(ND), .MAX_INFLIGHT(MI)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_src(rsp_src), .rsp_ready(rsp_ready), .inflight_cnt(inflight_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    int            src;
    int            t;
  } ent_t;

  ent_t          sb[$];
  int            errors = 0;
  int            checks = 0;
  int            cyc = 0;
  int            m_rr = 0;
  logic [DW-1:0] last_data = '0;
  int            last_src = 0;
  logic [NR-1:0] acc_mask = '0;
  logic [NR-1:0] pend = '0;
  logic [DW-1:0] pdata [NR];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference arbitration: grant lowest / next-in-turn valid requester when a credit exists.
  function automatic logic [NR-1:0] exp_grant(input logic [NR-1:0] v, input int rr, input bit ok);
    logic [NR-1:0] g;
    g = '0;
    if (!ok) return g;
`ifdef LATPIPE_SCHED_FIXED_PRIO_EN
    for (int k = 0; k < NR; k++) if (v[k]) begin g[k] = 1'b1; return g; end
`else
    for (int k = 0; k < NR; k++) if (v[(rr + k) % NR]) begin g[(rr + k) % NR] = 1'b1; return g; end
`endif
    return g;
  endfunction

  // Monitor: compares outputs against the model mid-cycle and records handshakes.
  always @(negedge clk) begin
    logic [NR-1:0] eg;
    if (rst) begin
      check("req_ready_in_rst", 64'(req_ready), 64'd0);
      sb.delete();
      m_rr = 0;
      last_data = '0;
      last_src = 0;
      acc_mask = '0;
    end else begin
      check("inflight_cnt", 64'(inflight_cnt), 64'(sb.size()));
      eg = exp_grant(req_valid, m_rr, sb.size() < MI);
      check("req_ready", 64'(req_ready), 64'(eg));
      check("rsp_valid", 64'(rsp_valid), 64'(sb.size() > 0 && sb[0].t + ND + 1 <= cyc));
      if (rsp_valid && sb.size() > 0) begin
        check("rsp_data", rsp_data, sb[0].data);
        check("rsp_src", 64'(rsp_src), 64'(sb[0].src));
        if (rsp_ready) begin
          last_data = sb[0].data;
          last_src = sb[0].src;
          void'(sb.pop_front());
        end
      end else if (!rsp_valid) begin
        check("rsp_data_hold", rsp_data, last_data);
        check("rsp_src_hold", 64'(rsp_src), 64'(last_src));
      end
      acc_mask = req_valid & req_ready;
      for (int i = 0; i < NR; i++) begin
        if (acc_mask[i]) begin
          sb.push_back('{data: req_data[i*DW +: DW], src: i, t: cyc});
          m_rr = (i + 1) % NR;
        end
      end
    end
  end

  // One cycle of stimulus: requesters hold valid/data until accepted.
  task automatic drive(input logic [NR-1:0] want, input bit rdy);
    for (int i = 0; i < NR; i++) begin
      if (acc_mask[i]) pend[i] = 1'b0;
      if (!pend[i] && want[i]) begin
        pend[i] = 1'b1;
        pdata[i] = {$urandom, $urandom};
      end
    end
    req_valid = pend;
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = pdata[i];
    rsp_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    pend = '0;
    repeat (n) drive('0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_data = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < NR; i++) pdata[i] = '0;
    @(posedge clk);
    #1;
    do_reset(3);
    repeat (6) drive('0, 1'b1);

    // Single request from requester 1.
    pend[1] = 1'b1;
    pdata[1] = 64'hA5;
    repeat (12) drive('0, 1'b1);

    // Both requesters continuously valid.
    repeat (10) drive(2'b11, 1'b1);
    repeat (12) drive('0, 1'b1);

    // Backpressure: fill all credits, release one pop, refill.
    repeat (16) drive(2'b01, 1'b0);
    drive(2'b01, 1'b1);
    repeat (4) drive(2'b01, 1'b0);
    repeat (3) drive(2'b01, 1'b1);
    repeat (30) drive('0, 1'b1);

    // Random traffic with mostly-ready then mostly-stalled consumer.
    repeat (1500) drive(NR'($urandom), $urandom_range(0, 3) != 0);
    repeat (500) drive(NR'($urandom), $urandom_range(0, 3) == 0);
    repeat (40) drive('0, 1'b1);

    // Reset with entries in both pipe and FIFO.
    repeat (6) drive(2'b11, 1'b0);
    drive('0, 1'b0);
    do_reset(1);
    repeat (12) drive('0, 1'b1);

    // Post-reset random traffic, then drain.
    repeat (300) drive(NR'($urandom), $urandom_range(0, 1) == 1);
    repeat (40) drive('0, 1'b1);
    check("drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
